// File: rtl/note_detect_pkg.sv
// note_detect_pkg: shared state type, default note table and width helper.
// Used by note_spectrum_detect (optional debug macro: NOTE_PEAK_DBG_EN).
package note_detect_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        SCORE,
        UPDATE
    } state_t;

    localparam int BIN_IDX_W   = 16;
    localparam int DEF_N_NOTES = 25;

    // C4..C6 chromatic on a 1024-point FFT at the 8 kHz down-sampled rate.
    localparam logic [DEF_N_NOTES-1:0][BIN_IDX_W-1:0] DEF_NOTE_BIN = {
        16'd134, 16'd126, 16'd119, 16'd113, 16'd106,
        16'd100, 16'd95,  16'd89,  16'd84,  16'd80,
        16'd75,  16'd71,  16'd67,  16'd63,  16'd60,
        16'd56,  16'd53,  16'd50,  16'd47,  16'd45,
        16'd42,  16'd40,  16'd38,  16'd35,  16'd33
    };

    function automatic int score_w(input int pwr_w, input int n_harm);
        return pwr_w + $clog2(n_harm + 1);
    endfunction

endpackage

// File: rtl/note_spectrum_detect_ram.sv
// bin_power_ram: single-port half-spectrum store, synchronous read.
// Written while a frame fills, read back while notes are scored.
module bin_power_ram #(
    parameter int DEPTH = 512,
    parameter int W     = 32,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [W-1:0]  wdata,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
        rdata <= mem[addr];
    end

endmodule

// File: rtl/note_spectrum_detect.sv
// note_spectrum_detect: harmonic-sum note scoring with on/off hysteresis.
// Define NOTE_PEAK_DBG_EN to add the o_peak_idx / o_peak_score ports.
module note_spectrum_detect
    import note_detect_pkg::*;
#(
    parameter int N_BINS     = 1024,
    parameter int N_NOTES    = DEF_N_NOTES,
    parameter int N_HARM     = 3,
    parameter int PWR_W      = 32,
    parameter int ON_FRAMES  = 2,
    parameter int OFF_FRAMES = 3,
    parameter logic [N_NOTES-1:0][BIN_IDX_W-1:0] NOTE_BIN = DEF_NOTE_BIN,
    localparam int SCORE_W   = score_w(PWR_W, N_HARM),
    localparam int KW        = (N_NOTES > 1) ? $clog2(N_NOTES) : 1
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_valid,
    input  logic               i_sop,
    input  logic [PWR_W-1:0]   i_pwr,
    input  logic [SCORE_W-1:0] i_thresh,
    output logic [N_NOTES-1:0] o_note,
    output logic               o_note_valid,
    output logic               o_busy,
    output logic               o_drop
`ifdef NOTE_PEAK_DBG_EN
    ,
    output logic [KW-1:0]      o_peak_idx,
    output logic [SCORE_W-1:0] o_peak_score
`endif
);

    localparam int HALF    = N_BINS / 2;
    localparam int AW      = $clog2(HALF);
    localparam int BC_W    = $clog2(N_BINS);
    localparam int HW      = $clog2(N_HARM + 1);
    localparam int AD_W    = BIN_IDX_W + HW;
    localparam int CNT_MAX = (ON_FRAMES > OFF_FRAMES) ? ON_FRAMES : OFF_FRAMES;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);

    state_t state, state_nxt;

    logic [BC_W-1:0]    bin_cnt;
    logic [KW-1:0]      k;
    logic [HW-1:0]      j;
    logic               upd_ph;
    logic               rd_ok;
    logic [SCORE_W-1:0] thresh_q;
    logic [SCORE_W-1:0] acc;
    logic [SCORE_W-1:0] score_now;
    logic [N_NOTES-1:0] above;
    logic [N_NOTES-1:0] note_st;
    logic [N_NOTES-1:0] note_nxt;
    logic [CNT_W-1:0]   cnt [N_NOTES];
    logic [CNT_W-1:0]   cnt_nxt [N_NOTES];

    logic [PWR_W-1:0]     rdata;
    logic [PWR_W-1:0]     contrib;
    logic [BIN_IDX_W-1:0] base;
    logic [AD_W-1:0]      haddr;
    logic [AW-1:0]        ram_addr;
    logic                 we;
    logic                 sop_start;
    logic                 last_bin;
    logic                 note_done;

    assign sop_start = i_valid & i_sop
                     & ((state == IDLE) | (state == FILL));
    assign last_bin  = (state == FILL) & i_valid & ~i_sop
                     & (bin_cnt == BC_W'(N_BINS - 1));
    assign we        = sop_start
                     | ((state == FILL) & i_valid
                        & (bin_cnt < BC_W'(HALF)));

    assign base      = NOTE_BIN[k];
    assign haddr     = AD_W'(base) * AD_W'(j + HW'(1));
    assign note_done = (state == SCORE) & (j == HW'(N_HARM));
    assign contrib   = rd_ok ? rdata : '0;
    assign score_now = ((j == HW'(1)) ? '0 : acc)
                     + SCORE_W'(contrib);

    always_comb begin
        ram_addr = bin_cnt[AW-1:0];
        if (state == SCORE) begin
            ram_addr = haddr[AW-1:0];
        end else if (i_sop) begin
            ram_addr = '0;
        end
    end

    bin_power_ram #(
        .DEPTH(HALF),
        .W    (PWR_W)
    ) u_ram (
        .clk  (i_clk),
        .we   (we),
        .addr (ram_addr),
        .wdata(i_pwr),
        .rdata(rdata)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        o_busy    = 1'b0;
        unique case (state)
            IDLE: begin
                if (i_valid && i_sop) state_nxt = FILL;
            end
            FILL: begin
                if (last_bin) state_nxt = SCORE;
            end
            SCORE: begin
                o_busy = 1'b1;
                if (note_done && k == KW'(N_NOTES - 1)) state_nxt = UPDATE;
            end
            UPDATE: begin
                o_busy = 1'b1;
                if (upd_ph) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // A differing frame counts toward the opposite state; agreement resets.
    always_comb begin
        for (int n = 0; n < N_NOTES; n++) begin
            note_nxt[n] = note_st[n];
            cnt_nxt[n]  = '0;
            if (above[n] != note_st[n]) begin
                cnt_nxt[n] = cnt[n] + CNT_W'(1);
                if (cnt_nxt[n] == (note_st[n] ? CNT_W'(OFF_FRAMES)
                                              : CNT_W'(ON_FRAMES))) begin
                    note_nxt[n] = ~note_st[n];
                    cnt_nxt[n]  = '0;
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            bin_cnt      <= '0;
            k            <= '0;
            j            <= '0;
            upd_ph       <= 1'b0;
            rd_ok        <= 1'b0;
            thresh_q     <= '0;
            acc          <= '0;
            above        <= '0;
            note_st      <= '0;
            o_note       <= '0;
            o_note_valid <= 1'b0;
            o_drop       <= 1'b0;
            for (int n = 0; n < N_NOTES; n++) cnt[n] <= '0;
        end else begin
            o_note_valid <= 1'b0;
            o_drop       <= o_busy & i_valid & i_sop;
            if (sop_start) begin
                bin_cnt <= BC_W'(1);
            end else if (state == FILL && i_valid) begin
                bin_cnt <= bin_cnt + BC_W'(1);
            end
            if (last_bin) begin
                thresh_q <= i_thresh;
                k        <= '0;
                j        <= '0;
            end
            if (state == SCORE) begin
                rd_ok <= (j < HW'(N_HARM)) && (haddr < AD_W'(HALF));
                if (j != '0) acc <= score_now;
                if (note_done) begin
                    above[k] <= (score_now >= thresh_q);
                    k        <= k + KW'(1);
                    j        <= '0;
                end else begin
                    j <= j + HW'(1);
                end
            end
            // First UPDATE cycle applies hysteresis, second publishes.
            if (state == UPDATE) begin
                upd_ph <= ~upd_ph;
                if (!upd_ph) begin
                    note_st <= note_nxt;
                    for (int n = 0; n < N_NOTES; n++) cnt[n] <= cnt_nxt[n];
                end else begin
                    o_note       <= note_st;
                    o_note_valid <= 1'b1;
                end
            end
        end
    end

`ifdef NOTE_PEAK_DBG_EN
    logic [KW-1:0]      best_idx;
    logic [SCORE_W-1:0] best_score;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            best_idx     <= '0;
            best_score   <= '0;
            o_peak_idx   <= '0;
            o_peak_score <= '0;
        end else begin
            if (note_done && (k == '0 || score_now > best_score)) begin
                best_idx   <= k;
                best_score <= score_now;
            end
            if (state == UPDATE && upd_ph) begin
                o_peak_idx   <= best_idx;
                o_peak_score <= best_score;
            end
        end
    end
`endif

endmodule
